// File: rtl/decoder_pkg.sv
// Shared definitions for the sequenced N-to-2^N decoder: mode codes and
// width-generic one-hot / polarity helpers.
package decoder_pkg;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Helpers work at a fixed maximum width; callers zero-extend and slice.
    localparam int unsigned MAX_SEL_W = 10;
    localparam int unsigned MAX_OUT_W = 2 ** MAX_SEL_W;

    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_OUT_W-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

    function automatic logic [MAX_OUT_W-1:0] apply_polarity(input logic [MAX_OUT_W-1:0] v,
                                                           input logic               active_low);
        return active_low ? ~v : v;
    endfunction

endpackage

// File: rtl/decoder_seq_nx2n_if.sv
// Select-value handshake between a producer and the sequenced decoder.
interface decoder_seq_nx2n_if #(
    parameter int unsigned SEL_W = 4
);
    logic             valid;
    logic             ready;
    logic [SEL_W-1:0] sel;

    modport master (output valid, output sel, input ready);
    modport slave  (input valid, input sel, output ready);
endinterface

// File: rtl/decoder_seq_nx2n_scan_timer.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while running and pulses
// tick on the last count.
module decoder_seq_nx2n_scan_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(DWELL + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    assign o_tick = i_run & (r_cnt == CNT_W'(DWELL - 1));

    always_comb begin
        w_cnt_next = r_cnt;
        if (i_clear) begin
            w_cnt_next = '0;
        end else if (i_run) begin
            w_cnt_next = o_tick ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

endmodule

// File: rtl/decoder_seq_nx2n.sv
// Registered N-to-2^N one-hot decoder with a direct (handshaked select) mode
// and a scan mode that steps through every line with a programmable dwell.
module decoder_seq_nx2n
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W      = 4,
    parameter int unsigned DWELL      = 4,
    parameter bit          ACTIVE_LOW = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enabled,
    input  logic                  i_mode,
    decoder_seq_nx2n_if.slave     in_bus,
    output logic [2**SEL_W-1:0]   o_outputs,
    output logic [SEL_W-1:0]      o_out_sel,
    output logic                  o_wrap
);

    localparam int unsigned OUT_W = 2 ** SEL_W;

    logic [SEL_W-1:0]     r_sel;
    logic [OUT_W-1:0]     r_out;
    logic                 r_wrap;

    logic                 w_direct;
    logic                 w_scan_run;
    logic                 w_accept;
    logic                 w_tick;
    logic [SEL_W-1:0]     w_sel_next;
    logic                 w_wrap_next;
    logic [MAX_OUT_W-1:0] w_active_wide;
    logic [MAX_OUT_W-1:0] w_idle_wide;
    logic [OUT_W-1:0]     w_active;
    logic [OUT_W-1:0]     w_idle;
    logic                 w_unused_hi;

    assign w_direct     = i_enabled & (i_mode == MODE_DIRECT);
    assign w_scan_run   = i_enabled & (i_mode == MODE_SCAN);
    assign in_bus.ready = w_direct & ~i_rst;
    assign w_accept     = in_bus.valid & in_bus.ready;

    // Direct mode keeps the dwell counter cleared so a switch to scan starts a fresh dwell.
    decoder_seq_nx2n_scan_timer #(
        .DWELL (DWELL)
    ) u_scan_timer (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_direct),
        .i_run   (w_scan_run),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_sel_next  = r_sel;
        w_wrap_next = 1'b0;
        if (w_accept) begin
            w_sel_next = in_bus.sel;
        end else if (w_tick) begin
            w_sel_next  = r_sel + SEL_W'(1);
            w_wrap_next = &r_sel;
        end
    end

    assign w_active_wide = apply_polarity(onehot(MAX_SEL_W'(w_sel_next)), ACTIVE_LOW);
    assign w_idle_wide   = apply_polarity('0, ACTIVE_LOW);
    assign w_active      = w_active_wide[OUT_W-1:0];
    assign w_idle        = w_idle_wide[OUT_W-1:0];
    assign w_unused_hi   = ^{w_active_wide >> OUT_W, w_idle_wide >> OUT_W};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel  <= '0;
            r_out  <= w_idle;
            r_wrap <= 1'b0;
        end else begin
            r_sel  <= w_sel_next;
            r_wrap <= w_wrap_next;
            r_out  <= i_enabled ? w_active : w_idle;
        end
    end

    assign o_outputs = r_out;
    assign o_out_sel = r_sel;
    assign o_wrap    = r_wrap;

endmodule

// File: tb/tb_decoder_seq_nx2n.sv
// Randomised bench for decoder_seq_nx2n: two instances (DWELL=4 active-high,
// DWELL=1 active-low) share stimulus and are compared against a rule model.
module tb_decoder_seq_nx2n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en;
    logic        mode;
    logic [15:0] out_a, out_b;
    logic [3:0]  sel_a, sel_b;
    logic        wrap_a, wrap_b;

    decoder_seq_nx2n_if #(.SEL_W(4)) bus_a ();
    decoder_seq_nx2n_if #(.SEL_W(4)) bus_b ();

    assign bus_b.valid = bus_a.valid;
    assign bus_b.sel   = bus_a.sel;

    decoder_seq_nx2n #(.SEL_W(4), .DWELL(4), .ACTIVE_LOW(1'b0)) dut_a (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enabled (en),
        .i_mode    (mode),
        .in_bus    (bus_a),
        .o_outputs (out_a),
        .o_out_sel (sel_a),
        .o_wrap    (wrap_a)
    );

    decoder_seq_nx2n #(.SEL_W(4), .DWELL(1), .ACTIVE_LOW(1'b1)) dut_b (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_enabled (en),
        .i_mode    (mode),
        .in_bus    (bus_b),
        .o_outputs (out_b),
        .o_out_sel (sel_b),
        .o_wrap    (wrap_b)
    );

    // Reference model state, one entry per instance.
    int          m_sel  [2];
    int          m_cnt  [2];
    logic [15:0] m_out  [2];
    logic        m_wrap [2];
    int          dw     [2] = '{4, 1};
    bit          al     [2] = '{1'b0, 1'b1};

    int n_checks = 0;
    int n_errors = 0;

    function automatic logic [15:0] line_val(input int sel, input bit active_low);
        logic [15:0] v;
        v = 16'(1) << sel;
        return active_low ? ~v : v;
    endfunction

    function automatic logic [15:0] idle_val(input bit active_low);
        return active_low ? 16'hFFFF : 16'h0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_sel[k]  = 0;
                m_cnt[k]  = 0;
                m_wrap[k] = 1'b0;
                m_out[k]  = idle_val(al[k]);
            end else if (!en) begin
                m_wrap[k] = 1'b0;
                m_out[k]  = idle_val(al[k]);
            end else if (mode == 1'b0) begin
                m_cnt[k]  = 0;
                m_wrap[k] = 1'b0;
                if (bus_a.valid) m_sel[k] = int'(bus_a.sel);
                m_out[k]  = line_val(m_sel[k], al[k]);
            end else begin
                m_wrap[k] = 1'b0;
                if (m_cnt[k] == dw[k] - 1) begin
                    m_cnt[k]  = 0;
                    m_sel[k]  = (m_sel[k] + 1) % 16;
                    m_wrap[k] = (m_sel[k] == 0);
                end else begin
                    m_cnt[k]++;
                end
                m_out[k] = line_val(m_sel[k], al[k]);
            end
        end
    endtask

    // One clock: drive inputs, check ready, clock, advance model, compare.
    task automatic step(input logic r, input logic e, input logic m, input logic v,
                        input logic [3:0] s);
        rst         = r;
        en          = e;
        mode        = m;
        bus_a.valid = v;
        bus_a.sel   = s;
        #1;
        check("ready_a", {31'd0, bus_a.ready}, {31'd0, e & ~m & ~r});
        check("ready_b", {31'd0, bus_b.ready}, {31'd0, e & ~m & ~r});
        @(posedge clk);
        model_edge();
        #1;
        check("out_a",  {16'd0, out_a},  {16'd0, m_out[0]});
        check("sel_a",  {28'd0, sel_a},  m_sel[0]);
        check("wrap_a", {31'd0, wrap_a}, {31'd0, m_wrap[0]});
        check("out_b",  {16'd0, out_b},  {16'd0, m_out[1]});
        check("sel_b",  {28'd0, sel_b},  m_sel[1]);
        check("wrap_b", {31'd0, wrap_b}, {31'd0, m_wrap[1]});
    endtask

    initial begin
        logic md;

        // Reset dominates a pending valid select.
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        step(1'b1, 1'b1, 1'b0, 1'b1, 4'h5);
        check("rst_out_a", {16'd0, out_a}, 32'h0000);
        check("rst_out_b", {16'd0, out_b}, 32'hFFFF);
        check("rst_sel_a", {28'd0, sel_a}, 32'h0);

        // Back-to-back direct accepts.
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h0);
        check("dir0", {16'd0, out_a}, 32'h0001);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h1);
        check("dir1", {16'd0, out_a}, 32'h0002);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h3);
        check("dir3", {16'd0, out_a}, 32'h0008);
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'h4);
        check("dir4", {16'd0, out_a}, 32'h0010);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h9);
        check("dir_hold", {16'd0, out_a}, 32'h0010);

        // Enable drop freezes the select and blanks the lines.
        step(1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
        check("dis_out", {16'd0, out_a}, 32'h0000);
        check("dis_sel", {28'd0, sel_a}, 32'h4);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("reen_out", {16'd0, out_a}, 32'h0010);

        // Scan from line 14 through the wrap.
        step(1'b0, 1'b1, 1'b0, 1'b1, 4'hE);
        check("scan_start", {16'd0, out_a}, 32'h4000);
        for (int i = 1; i <= 9; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b1, 4'h3);
            if (i <= 3) check("scan_l14", {16'd0, out_a}, 32'h4000);
            else if (i <= 7) check("scan_l15", {16'd0, out_a}, 32'h8000);
            else if (i == 8) check("scan_wrap", {31'd0, wrap_a}, 32'h1);
            else check("scan_wrap_end", {31'd0, wrap_a}, 32'h0);
        end
        check("scan_l0", {16'd0, out_a}, 32'h0001);

        // Mode change mid-dwell clears the counter; reset mid-dwell blanks.
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("mode_hold", {16'd0, out_a}, 32'h0001);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        check("redwell_wait", {28'd0, sel_a}, 32'h0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        check("redwell_step", {28'd0, sel_a}, 32'h1);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
        check("rst_mid_a", {16'd0, out_a}, 32'h0000);
        check("rst_mid_b", {16'd0, out_b}, 32'hFFFF);

        // Active-low, single-cycle dwell: the low bit walks each cycle.
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
        check("walk0", {16'd0, out_b}, 32'hFFFE);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        check("walk1", {16'd0, out_b}, 32'hFFFD);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
        check("walk2", {16'd0, out_b}, 32'hFFFB);

        // Random traffic against the model.
        md = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) md = ~md;
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) != 0), md,
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decoder_seq_nx2n.md
Name: decoder_seq_nx2n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder; generalises the fixed 4x16 combinational decoder.
- Two modes:
  - Direct: decodes a select value accepted through a valid/ready handshake.
  - Scan: auto-steps the active output through all 2^N lines, holding each line for a programmable dwell time.
- Targets display/row multiplexing and bus-slave select generation in the lab modules.

Parameters:
- SEL_W, 4, select width N; OUT_W = 2**SEL_W is a derived localparam (16 by default).
- DWELL, 4, clock cycles each line stays active in scan mode; legal range 1..65535.
- ACTIVE_LOW, 0, output polarity: 0 means the active line is 1; 1 means the active line is 0 and the others are 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset.
- enabled  in  1  global enable; 0 forces all outputs inactive.
- mode  in  1  0 = direct, 1 = scan.
- in_valid  in  1  select value present on inputs (direct mode).
- in_ready  out  1  block can accept inputs this cycle.
- inputs  in  SEL_W  select value.
- outputs  out  OUT_W  registered one-hot line outputs.
- out_sel  out  SEL_W  index of the currently selected line.
- wrap  out  1  one-cycle pulse when scan wraps from line OUT_W-1 to line 0.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a clk edge, dominates all other inputs, including mid-dwell or mid-handshake):
  - outputs = all inactive (0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1).
  - out_sel = 0, wrap = 0, dwell counter = 0.
- in_ready = enabled & ~mode & ~rst. This is combinational, with no dependence on in_valid.
- Direct mode, accept on edge with in_valid & in_ready:
  - out_sel <= inputs.
  - outputs <= onehot(inputs), polarity-adjusted.
  - Latency 1 cycle; back-to-back accepts every cycle are allowed.
  - With no accept, out_sel and outputs hold.
- Scan mode (mode=1, enabled=1):
  - Dwell counter counts 0..DWELL-1.
  - At the edge where counter==DWELL-1: counter <= 0, out_sel <= out_sel+1 modulo 2^SEL_W, outputs <= onehot(new out_sel).
  - wrap is asserted in the same cycle that out_sel becomes 0 from OUT_W-1, and is otherwise 0.
  - DWELL=1 steps every cycle.
- Scan-mode handshake: in_valid is ignored (in_ready=0); no data is lost or queued.
- Mode change 0->1: counter cleared; scan starts from the current out_sel; first step occurs DWELL cycles later. outputs show onehot(out_sel) from the first scan cycle.
- Mode change 1->0 mid-dwell: counter cleared; out_sel and outputs hold until the next accept.
- enabled=0:
  - outputs become inactive on the next edge.
  - out_sel, dwell counter and mode state freeze; wrap=0.
  - On re-enable, outputs = onehot(out_sel) after one edge and scan resumes from the frozen counter value.
- Width rules: out_sel increments in SEL_W bits with natural wrap; onehot index is always in range (no invalid codes).

Decomposition:
- Shared package decoder_pkg:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - function onehot(sel) returning an OUT_W-wide vector, parametrised by SEL_W.
  - Polarity helper applying ACTIVE_LOW.
- One natural sub-module, scan_timer:
  - DWELL-parametrised counter with clk, rst, clear, run inputs and a tick output.
  - Width is $clog2(DWELL+1).
  - Top level owns out_sel, outputs and wrap.

Test Plan (SEL_W=4, DWELL=4, ACTIVE_LOW=0 unless stated):
- Reset: rst=1 for 2 cycles with in_valid=1, inputs=4'h5 -> outputs=16'h0000, out_sel=0, wrap=0 throughout.
- Direct sequence: enabled=1, mode=0, accept 4'h0, 4'h1, 4'h3, 4'h4 on consecutive cycles -> one cycle later each: outputs=16'h0001, 16'h0002, 16'h0008, 16'h0010; in_valid=0 afterwards -> 16'h0010 holds.
- Enable drop: after outputs=16'h0010, set enabled=0 with in_valid=1, inputs=4'h5 -> in_ready=0, outputs=16'h0000 next cycle, out_sel stays 4; re-enable -> 16'h0010.
- Scan wrap: set out_sel=4'hE via direct, then mode=1 -> 16'h4000 for 4 cycles, then 16'h8000 for 4 cycles, then 16'h0001 with wrap=1 for exactly that one cycle.
- Mode/reset mid-dwell: scan, switch mode=0 two cycles into a dwell -> outputs hold; switch back -> next step exactly 4 cycles later; rst asserted mid-dwell -> all zero next edge.
- Polarity/edge params: ACTIVE_LOW=1, DWELL=1 -> inactive lines high, reset outputs=16'hFFFF, and the low bit walks one position per cycle, giving 16'hFFFE, 16'hFFFD, ...
